nock_mem_ctrl: RTL and testbench
================================

Name: nock_mem_ctrl

Overview:
- Multi-requester memory controller for the NockPU cell store; successor to the single-requester memory unit.
- Owns a synchronous single-port RAM and serves NUM_PORTS requesters through round-robin arbitration.
- Operations: read, write, bump-allocate free cells, and free-pointer reset.
- Out-of-memory is reported as an error response instead of a hang.

Parameters:
ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 64, memory word width (must be >= ADDR_WIDTH+1)
NUM_PORTS, 2, number of requester ports (1..8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
power  in  1  clock enable; when low, FSM and all registers hold
execute  in  NUM_PORTS  per-port request, level, held until that port's done
func  in  2*NUM_PORTS  per-port op: 00 GET_CONTENTS, 01 SET_CONTENTS, 10 GET_FREE, 11 SET_FREE_PTR
address  in  ADDR_WIDTH*NUM_PORTS  per-port word address
write_data  in  DATA_WIDTH*NUM_PORTS  per-port write data; GET_FREE uses bits [ADDR_WIDTH:0] as cell count
done  out  NUM_PORTS  one-cycle per-port completion pulse
err  out  1  valid with done: request failed
read_data  out  DATA_WIDTH  valid with done for GET_CONTENTS; held otherwise
free_addr  out  ADDR_WIDTH  base of last successful allocation; valid with done for GET_FREE
free_ptr  out  ADDR_WIDTH  current next-free address
oom  out  1  sticky out-of-memory flag; cleared only by reset or SET_FREE_PTR
ready  out  1  high while FSM is in IDLE
state  out  4  FSM state, for debug

Behaviour:
- Reset (rst low, async):
  - state=INIT_RD; done=0, err=0, read_data=0, free_addr=0, free_ptr=0, oom=0, ready=0.
  - RAM write enable deasserted; arbiter pointer selects port 0 first.
- Reset mid-operation aborts any transaction; no done is issued for it.
- RAM: synchronous, 1-cycle read latency; write takes effect on the edge where wren is high.
- Init sequence (one state per cycle while power=1):
  - INIT_RD: drive addr 0.
  - INIT_WAIT
  - INIT_LOAD: free_ptr <= q[ADDR_WIDTH-1:0].
  - INIT_CLR: write 0 to word 0 (nil).
  - IDLE.
- Requests arriving during init wait; no done is issued until IDLE.
- IDLE, arbitration:
  - Among ports with execute=1 and done=0, grant the first index after the last-granted port, wrapping.
  - Latch func, address and write_data of the granted port.
  - No requests: stay in IDLE.
- GET_CONTENTS: IDLE -> RD_WAIT -> RD_FIN. RD_FIN registers read_data and pulses done. Latency from the execute-sampling edge to done high is 3 cycles.
- SET_CONTENTS: IDLE asserts wren -> WR_WAIT drops wren -> WR_FIN pulses done. Latency is 3 cycles.
- GET_FREE, count n = write_data[ADDR_WIDTH:0]:
  - The sum free_ptr + n is computed ADDR_WIDTH+2 bits wide.
  - If the sum <= DEPTH-1: free_addr <= free_ptr, free_ptr <= free_ptr + n, then FREE_FIN pulses done with err=0.
  - Otherwise: free_ptr unchanged, oom <= 1, FREE_FIN pulses done with err=1.
  - Latency is 2 cycles.
  - n=0 succeeds and returns free_addr=free_ptr with the pointer unchanged.
- SET_FREE_PTR: free_ptr <= address, oom <= 0, then FREE_FIN pulses done. Used by the future garbage collector.
- FIN states return to IDLE. The port whose done is high in that cycle is not eligible for grant; the requester drops execute on seeing done.
- Only one transaction is in flight at a time; done is one-hot or zero.
- Changing a port's inputs while its execute is high is undefined, except after done.

Optional Feature:
MEM_BOUNDS_CHECK_EN
- Defined:
  - GET_CONTENTS or SET_CONTENTS to address 0, or to address >= free_ptr, completes with err=1.
  - No RAM write occurs; read_data is unchanged.
  - Latency is 2 cycles (via FREE_FIN).
- Undefined: no address checking; all addresses are accessed normally.

Test Plan:
- Init: word0 preloaded 0x1F0 -> after reset release, ready high after 4 cycles; free_ptr=0x1F0; word0 reads back 0.
- Port0 SET addr 0x200 data 0xDEADBEEF, then GET 0x200 -> done after 3 cycles each; read_data=0xDEADBEEF; err=0.
- Ports 0 and 1 issue GET_FREE n=4 in the same cycle, free_ptr=0x1F0 -> port0 gets 0x1F0, then port1 gets 0x1F4; free_ptr=0x1F8; a repeat of both grants port1 first.
- free_ptr=0x3FC, GET_FREE n=4 -> err=1, oom=1, free_ptr stays 0x3FC; n=3 -> free_addr=0x3FC, free_ptr=0x3FF.
- SET_FREE_PTR addr 0x100 with oom=1 -> oom=0, free_ptr=0x100.
- With MEM_BOUNDS_CHECK_EN, free_ptr=0x100: GET 0x150 -> err=1 in 2 cycles; SET 0x0 -> err=1 and word0 unchanged. Mid-read rst pulse -> no done; init reruns.

Source files
------------

// File: rtl/nock_mem_ctrl_if.sv
// Requester-side bus of the NockPU cell-store controller: per-port requests
// packed side by side, shared response/status returned to all ports.
interface nock_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]            execute;
  logic [2*NUM_PORTS-1:0]          func;
  logic [ADDR_WIDTH*NUM_PORTS-1:0] address;
  logic [DATA_WIDTH*NUM_PORTS-1:0] write_data;
  logic [NUM_PORTS-1:0]            done;
  logic                            err;
  logic [DATA_WIDTH-1:0]           read_data;
  logic [ADDR_WIDTH-1:0]           free_addr;
  logic [ADDR_WIDTH-1:0]           free_ptr;
  logic                            oom;
  logic                            ready;
  logic [3:0]                      state;

  modport master (
    output execute, func, address, write_data,
    input  done, err, read_data, free_addr, free_ptr, oom, ready, state
  );

  modport slave (
    input  execute, func, address, write_data,
    output done, err, read_data, free_addr, free_ptr, oom, ready, state
  );
endinterface

// File: rtl/nock_mem_ctrl.sv
// Multi-port NockPU cell-store controller: round-robin arbiter, single-port RAM, bump allocator.
// Define MEM_BOUNDS_CHECK_EN to reject GET/SET_CONTENTS at address 0 or at/above free_ptr.
module nock_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  nock_mem_ctrl_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW    = ADDR_WIDTH + 2;

  localparam logic [1:0] F_GET_CONTENTS = 2'b00;
  localparam logic [1:0] F_SET_CONTENTS = 2'b01;
  localparam logic [1:0] F_GET_FREE     = 2'b10;
  localparam logic [1:0] F_SET_FREE_PTR = 2'b11;

  typedef enum logic [3:0] {
    S_INIT_RD   = 4'd0,
    S_INIT_WAIT = 4'd1,
    S_INIT_LOAD = 4'd2,
    S_INIT_CLR  = 4'd3,
    S_IDLE      = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_RD_FIN    = 4'd6,
    S_WR_WAIT   = 4'd7,
    S_WR_FIN    = 4'd8,
    S_FREE_FIN  = 4'd9
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_ram_wren;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  logic [1:0]            w_func  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];

  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_gnt_valid;
  logic [PW-1:0]         w_gnt_idx;
  logic [1:0]            w_sel_func;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_bad;

  logic [PW-1:0]         r_last;
  logic [1:0]            r_func;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [NUM_PORTS-1:0]  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [ADDR_WIDTH-1:0] r_free_addr;
  logic [ADDR_WIDTH-1:0] r_free_ptr;
  logic                  r_oom;

  logic [SW-1:0]         w_sum;
  logic                  w_fits;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_func[i]  = bus.func[2*i +: 2];
      w_addr[i]  = bus.address[ADDR_WIDTH*i +: ADDR_WIDTH];
      w_wdata[i] = bus.write_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // A port whose done is high this cycle has just finished and must not be re-granted.
  assign w_elig = bus.execute & ~r_done;

  always_comb begin
    int j;
    j           = 0;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      j = (int'(r_last) + k) % NUM_PORTS;
      if (!w_gnt_valid && w_elig[j]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = PW'(j);
      end
    end
  end

  assign w_sel_func  = w_func[w_gnt_idx];
  assign w_sel_addr  = w_addr[w_gnt_idx];
  assign w_sel_wdata = w_wdata[w_gnt_idx];

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_bad = ((w_sel_func == F_GET_CONTENTS) || (w_sel_func == F_SET_CONTENTS)) &&
                 ((w_sel_addr == '0) || (w_sel_addr >= r_free_ptr));
`else
  assign w_bad = 1'b0;
`endif

  // Two extra bits so that neither the count nor the carry can wrap the compare.
  assign w_sum  = SW'(r_free_ptr) + SW'(r_count);
  assign w_fits = (w_sum <= SW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (power) begin
      if (w_ram_wren) begin
        r_mem[w_ram_addr] <= w_ram_wdata;
      end
      r_q <= r_mem[w_ram_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT_RD;
    end else if (power) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ram_addr  = '0;
    w_ram_wren  = 1'b0;
    w_ram_wdata = '0;
    case (r_state)
      S_INIT_RD:   w_next = S_INIT_WAIT;
      S_INIT_WAIT: w_next = S_INIT_LOAD;
      S_INIT_LOAD: w_next = S_INIT_CLR;
      S_INIT_CLR: begin
        w_ram_wren = 1'b1;
        w_next     = S_IDLE;
      end
      S_IDLE: begin
        w_ram_addr = w_sel_addr;
        if (w_gnt_valid) begin
          if (w_bad) begin
            w_next = S_FREE_FIN;
          end else begin
            case (w_sel_func)
              F_GET_CONTENTS: w_next = S_RD_WAIT;
              F_SET_CONTENTS: begin
                w_ram_wren  = 1'b1;
                w_ram_wdata = w_sel_wdata;
                w_next      = S_WR_WAIT;
              end
              default:        w_next = S_FREE_FIN;
            endcase
          end
        end
      end
      S_RD_WAIT: begin
        w_ram_addr = r_addr;
        w_next     = S_RD_FIN;
      end
      S_RD_FIN: begin
        w_ram_addr = r_addr;
        w_next     = S_IDLE;
      end
      S_WR_WAIT:  w_next = S_WR_FIN;
      S_WR_FIN:   w_next = S_IDLE;
      S_FREE_FIN: w_next = S_IDLE;
      default:    w_next = S_INIT_RD;
    endcase
  end

  // FREE_FIN also finishes bounds-rejected GET/SET, which land in the default branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= PW'(NUM_PORTS - 1);
      r_func      <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_read_data <= '0;
      r_free_addr <= '0;
      r_free_ptr  <= '0;
      r_oom       <= 1'b0;
    end else if (power) begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        S_INIT_LOAD: r_free_ptr <= r_q[ADDR_WIDTH-1:0];
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_last  <= w_gnt_idx;
            r_func  <= w_sel_func;
            r_addr  <= w_sel_addr;
            r_count <= w_sel_wdata[ADDR_WIDTH:0];
          end
        end
        S_RD_FIN: begin
          r_read_data    <= r_q;
          r_done[r_last] <= 1'b1;
        end
        S_WR_FIN: r_done[r_last] <= 1'b1;
        S_FREE_FIN: begin
          r_done[r_last] <= 1'b1;
          case (r_func)
            F_GET_FREE: begin
              if (w_fits) begin
                r_free_addr <= r_free_ptr;
                r_free_ptr  <= w_sum[ADDR_WIDTH-1:0];
              end else begin
                r_oom <= 1'b1;
                r_err <= 1'b1;
              end
            end
            F_SET_FREE_PTR: begin
              r_free_ptr <= r_addr;
              r_oom      <= 1'b0;
            end
            default: r_err <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.read_data = r_read_data;
  assign bus.free_addr = r_free_addr;
  assign bus.free_ptr  = r_free_ptr;
  assign bus.oom       = r_oom;
  assign bus.ready     = (r_state == S_IDLE);
  assign bus.state     = r_state;

endmodule

// File: tb/tb_nock_mem_ctrl.sv
// Directed bench for nock_mem_ctrl: init, read/write, round-robin allocation,
// out-of-memory, pointer reset, optional bounds check, reset abort and power hold.
module tb_nock_mem_ctrl;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int NP = 2;

  localparam logic [1:0] F_GET  = 2'b00;
  localparam logic [1:0] F_SET  = 2'b01;
  localparam logic [1:0] F_FREE = 2'b10;
  localparam logic [1:0] F_FPTR = 2'b11;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [AW-1:0] RW_ADDR = 10'h1E0;
`else
  localparam logic [AW-1:0] RW_ADDR = 10'h200;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic power = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  nock_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  nock_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk   (clk),
    .rst   (rst),
    .power (power),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input logic [1:0] f, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.func[port*2 +: 2]        = f;
    bus.address[port*AW +: AW]   = a;
    bus.write_data[port*DW +: DW] = d;
    bus.execute[port]            = 1'b1;
  endtask

  // Returns -1 on timeout; the extra tick lets the finished port become eligible again.
  task automatic waitDone(input int port, input int budget, output int lat, output logic errSeen);
    lat     = -1;
    errSeen = 1'bx;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.done[port]) begin
        lat     = c;
        errSeen = bus.err;
        break;
      end
    end
    bus.execute[port] = 1'b0;
    tick();
  endtask

  task automatic waitReady(input int budget, output int lat, output logic sawDone);
    lat     = -1;
    sawDone = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.done !== '0) sawDone = 1'b1;
      if (bus.ready === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic runPair(input logic [DW-1:0] n, output int t0, output int t1,
                         output logic [AW-1:0] a0, output logic [AW-1:0] a1);
    t0 = -1;
    t1 = -1;
    a0 = '0;
    a1 = '0;
    issue(0, F_FREE, '0, n);
    issue(1, F_FREE, '0, n);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.done[0]) begin
        t0 = c;
        a0 = bus.free_addr;
        bus.execute[0] = 1'b0;
      end
      if (bus.done[1]) begin
        t1 = c;
        a1 = bus.free_addr;
        bus.execute[1] = 1'b0;
      end
      if (t0 > 0 && t1 > 0) break;
    end
    bus.execute = '0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    assertCount++; if (bus.state !== 4'd0) begin failCount++; $display("[TB] FAIL reset_state got %0h want 0", bus.state); end
    assertCount++; if (bus.done !== 2'b00) begin failCount++; $display("[TB] FAIL reset_done got %b want 00", bus.done); end
    assertCount++; if (bus.err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
    assertCount++; if (bus.read_data !== 64'h0) begin failCount++; $display("[TB] FAIL reset_read_data got %h want 0", bus.read_data); end
    assertCount++; if (bus.free_addr !== 10'h0) begin failCount++; $display("[TB] FAIL reset_free_addr got %h want 0", bus.free_addr); end
    assertCount++; if (bus.free_ptr !== 10'h0) begin failCount++; $display("[TB] FAIL reset_free_ptr got %h want 0", bus.free_ptr); end
    assertCount++; if (bus.oom !== 1'b0) begin failCount++; $display("[TB] FAIL reset_oom got %b want 0", bus.oom); end
    assertCount++; if (bus.ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got %b want 0", bus.ready); end
  endtask

  task automatic test_init();
    int   lat;
    logic e;
    logic sawDone;
    rst = 1'b1;
    waitReady(10, lat, sawDone);
    assertCount++; if (lat !== 4) begin failCount++; $display("[TB] FAIL boot_ready_latency got %0d want 4", lat); end
`ifndef MEM_BOUNDS_CHECK_EN
    issue(0, F_SET, 10'h000, 64'h1F0);
    waitDone(0, 10, lat, e);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    waitReady(10, lat, sawDone);
    assertCount++; if (lat !== 4) begin failCount++; $display("[TB] FAIL init_ready_latency got %0d want 4", lat); end
    assertCount++; if (bus.free_ptr !== 10'h1F0) begin failCount++; $display("[TB] FAIL init_free_ptr got %h want 1f0", bus.free_ptr); end
    issue(1, F_GET, 10'h000, '0);
    waitDone(1, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL init_word0_latency got %0d want 3", lat); end
    assertCount++; if (bus.read_data !== 64'h0) begin failCount++; $display("[TB] FAIL init_word0_cleared got %h want 0", bus.read_data); end
`else
    issue(1, F_FPTR, 10'h1F0, '0);
    waitDone(1, 10, lat, e);
    assertCount++; if (bus.free_ptr !== 10'h1F0) begin failCount++; $display("[TB] FAIL init_free_ptr got %h want 1f0", bus.free_ptr); end
    assertCount++; if (dut.r_mem[0] !== 64'h0) begin failCount++; $display("[TB] FAIL init_word0_cleared got %h want 0", dut.r_mem[0]); end
`endif
  endtask

  task automatic test_set_get();
    int   lat;
    logic e;
    issue(1, F_SET, RW_ADDR, 64'hDEADBEEF);
    waitDone(1, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL set_latency got %0d want 3", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL set_err got %b want 0", e); end
    issue(1, F_GET, RW_ADDR, '0);
    waitDone(1, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL get_latency got %0d want 3", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL get_err got %b want 0", e); end
    assertCount++; if (bus.read_data !== 64'hDEADBEEF) begin failCount++; $display("[TB] FAIL get_data got %h want deadbeef", bus.read_data); end
  endtask

  task automatic test_arbitration();
    int            t0, t1, lat;
    logic [AW-1:0] a0, a1;
    logic          e;
    runPair(64'd4, t0, t1, a0, a1);
    assertCount++; if (t0 !== 2) begin failCount++; $display("[TB] FAIL rr1_port0_time got %0d want 2", t0); end
    assertCount++; if (a0 !== 10'h1F0) begin failCount++; $display("[TB] FAIL rr1_port0_addr got %h want 1f0", a0); end
    assertCount++; if (t1 !== 4) begin failCount++; $display("[TB] FAIL rr1_port1_time got %0d want 4", t1); end
    assertCount++; if (a1 !== 10'h1F4) begin failCount++; $display("[TB] FAIL rr1_port1_addr got %h want 1f4", a1); end
    assertCount++; if (bus.free_ptr !== 10'h1F8) begin failCount++; $display("[TB] FAIL rr1_free_ptr got %h want 1f8", bus.free_ptr); end
    issue(0, F_FREE, '0, 64'd0);
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL zero_latency got %0d want 2", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL zero_err got %b want 0", e); end
    assertCount++; if (bus.free_addr !== 10'h1F8) begin failCount++; $display("[TB] FAIL zero_free_addr got %h want 1f8", bus.free_addr); end
    assertCount++; if (bus.free_ptr !== 10'h1F8) begin failCount++; $display("[TB] FAIL zero_free_ptr got %h want 1f8", bus.free_ptr); end
    runPair(64'd4, t0, t1, a0, a1);
    assertCount++; if (t1 !== 2) begin failCount++; $display("[TB] FAIL rr2_port1_time got %0d want 2", t1); end
    assertCount++; if (a1 !== 10'h1F8) begin failCount++; $display("[TB] FAIL rr2_port1_addr got %h want 1f8", a1); end
    assertCount++; if (t0 !== 4) begin failCount++; $display("[TB] FAIL rr2_port0_time got %0d want 4", t0); end
    assertCount++; if (a0 !== 10'h1FC) begin failCount++; $display("[TB] FAIL rr2_port0_addr got %h want 1fc", a0); end
    assertCount++; if (bus.free_ptr !== 10'h200) begin failCount++; $display("[TB] FAIL rr2_free_ptr got %h want 200", bus.free_ptr); end
  endtask

  task automatic test_oom();
    int   lat;
    logic e;
    issue(0, F_FPTR, 10'h3FC, '0);
    waitDone(0, 10, lat, e);
    assertCount++; if (bus.free_ptr !== 10'h3FC) begin failCount++; $display("[TB] FAIL oom_setup_ptr got %h want 3fc", bus.free_ptr); end
    issue(0, F_FREE, '0, 64'd4);
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL oom_latency got %0d want 2", lat); end
    assertCount++; if (e !== 1'b1) begin failCount++; $display("[TB] FAIL oom_err got %b want 1", e); end
    assertCount++; if (bus.oom !== 1'b1) begin failCount++; $display("[TB] FAIL oom_flag got %b want 1", bus.oom); end
    assertCount++; if (bus.free_ptr !== 10'h3FC) begin failCount++; $display("[TB] FAIL oom_ptr_held got %h want 3fc", bus.free_ptr); end
    issue(0, F_FREE, '0, 64'd3);
    waitDone(0, 10, lat, e);
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL fit_err got %b want 0", e); end
    assertCount++; if (bus.free_addr !== 10'h3FC) begin failCount++; $display("[TB] FAIL fit_free_addr got %h want 3fc", bus.free_addr); end
    assertCount++; if (bus.free_ptr !== 10'h3FF) begin failCount++; $display("[TB] FAIL fit_free_ptr got %h want 3ff", bus.free_ptr); end
    assertCount++; if (bus.oom !== 1'b1) begin failCount++; $display("[TB] FAIL oom_sticky got %b want 1", bus.oom); end
  endtask

  task automatic test_set_free_ptr();
    int   lat;
    logic e;
    issue(1, F_FPTR, 10'h100, '0);
    waitDone(1, 10, lat, e);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL fptr_latency got %0d want 2", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL fptr_err got %b want 0", e); end
    assertCount++; if (bus.oom !== 1'b0) begin failCount++; $display("[TB] FAIL fptr_oom_clear got %b want 0", bus.oom); end
    assertCount++; if (bus.free_ptr !== 10'h100) begin failCount++; $display("[TB] FAIL fptr_value got %h want 100", bus.free_ptr); end
  endtask

  task automatic test_bounds();
    int   lat;
    logic e;
`ifdef MEM_BOUNDS_CHECK_EN
    issue(0, F_GET, 10'h150, '0);
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL bounds_get_latency got %0d want 2", lat); end
    assertCount++; if (e !== 1'b1) begin failCount++; $display("[TB] FAIL bounds_get_err got %b want 1", e); end
    assertCount++; if (bus.read_data !== 64'hDEADBEEF) begin failCount++; $display("[TB] FAIL bounds_data_held got %h want deadbeef", bus.read_data); end
    issue(0, F_SET, 10'h000, 64'h55);
    waitDone(0, 10, lat, e);
    assertCount++; if (e !== 1'b1) begin failCount++; $display("[TB] FAIL bounds_set0_err got %b want 1", e); end
    assertCount++; if (dut.r_mem[0] !== 64'h0) begin failCount++; $display("[TB] FAIL bounds_word0_kept got %h want 0", dut.r_mem[0]); end
    issue(0, F_GET, 10'h080, '0);
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL bounds_inrange_latency got %0d want 3", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL bounds_inrange_err got %b want 0", e); end
`else
    issue(0, F_GET, 10'h150, '0);
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL nobounds_latency got %0d want 3", lat); end
    assertCount++; if (e !== 1'b0) begin failCount++; $display("[TB] FAIL nobounds_err got %b want 0", e); end
`endif
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic e;
    logic sawDone;
    issue(1, F_GET, RW_ADDR, '0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    assertCount++; if (bus.state !== 4'd0) begin failCount++; $display("[TB] FAIL abort_state got %0h want 0", bus.state); end
    assertCount++; if (bus.done !== 2'b00) begin failCount++; $display("[TB] FAIL abort_done got %b want 00", bus.done); end
    assertCount++; if (bus.read_data !== 64'h0) begin failCount++; $display("[TB] FAIL abort_read_data got %h want 0", bus.read_data); end
    rst = 1'b1;
    waitReady(10, lat, sawDone);
    assertCount++; if (lat !== 4) begin failCount++; $display("[TB] FAIL rerun_ready_latency got %0d want 4", lat); end
    assertCount++; if (sawDone !== 1'b0) begin failCount++; $display("[TB] FAIL rerun_no_done got %b want 0", sawDone); end
    assertCount++; if (bus.free_ptr !== 10'h0) begin failCount++; $display("[TB] FAIL rerun_free_ptr got %h want 0", bus.free_ptr); end
`ifndef MEM_BOUNDS_CHECK_EN
    waitDone(1, 10, lat, e);
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL pending_latency got %0d want 3", lat); end
    assertCount++; if (bus.read_data !== 64'hDEADBEEF) begin failCount++; $display("[TB] FAIL pending_data got %h want deadbeef", bus.read_data); end
`else
    bus.execute = '0;
    tick();
    tick();
`endif
  endtask

  task automatic test_power();
    int   lat;
    logic e;
    logic anyDone;
    anyDone = 1'b0;
    issue(0, F_FPTR, 10'h123, '0);
    power = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done !== '0) anyDone = 1'b1;
    end
    assertCount++; if (anyDone !== 1'b0) begin failCount++; $display("[TB] FAIL power_hold_done got %b want 0", anyDone); end
    assertCount++; if (bus.ready !== 1'b1) begin failCount++; $display("[TB] FAIL power_hold_idle got %b want 1", bus.ready); end
    assertCount++; if (bus.free_ptr !== 10'h0) begin failCount++; $display("[TB] FAIL power_hold_ptr got %h want 0", bus.free_ptr); end
    power = 1'b1;
    waitDone(0, 10, lat, e);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL power_resume_latency got %0d want 2", lat); end
    assertCount++; if (bus.free_ptr !== 10'h123) begin failCount++; $display("[TB] FAIL power_resume_ptr got %h want 123", bus.free_ptr); end
  endtask

  initial begin
    bus.execute    = '0;
    bus.func       = '0;
    bus.address    = '0;
    bus.write_data = '0;
    test_reset();
    test_init();
    test_set_get();
    test_arbitration();
    test_oom();
    test_set_free_ptr();
    test_bounds();
    test_reset_mid();
    test_power();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d assertions", assertCount);
    $fatal(1, "[TB] watchdog");
  end
endmodule
